mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage directly downstream of the EX/MEM register. It consumes that register's outputs.
//  It performs the load/store on a req/ack data-memory port and resolves the branch from pc_src/zero.
//  It also holds the MEM/WB pipeline register that feeds write-back and forwarding.
//  It raises stall while a memory access is outstanding, so that upstream stages freeze.
// PARAMETERS
//  DATA_W   8   data / ALU-result / memory-address width
//  REG_W    3   register-file index width
//  PC_W     12  program-counter width
//  TIMEOUT  15  max WAIT cycles without mem_ack before the access is aborted (1..255)
// PORTS
//  clk                     in   1       rising-edge clock
//  rst_n                   in   1       asynchronous, active-low reset
//  in_valid                in   1       EX/MEM holds a real instruction (0 = bubble)
//  in_alu_result           in   DATA_W  ALU result; this is the memory address for a load/store
//  in_data_2               in   DATA_W  store data
//  in_reg_write            in   REG_W   destination register
//  in_zero                 in   1       ALU zero flag
//  in_new_branch_pc        in   PC_W    branch target
//  in_MEM_mem_read_write   in   1       1 = store, 0 = no store
//  in_MEM_pc_src           in   2       00 seq, 01 beq, 10 bne, 11 jump
//  in_WB_mem_or_alu        in   1       1 = load (WB takes memory data), 0 = WB takes ALU result
//  in_WB_reg_write_signal  in   1       write-back enable
//  mem_req                 out  1       memory request
//  mem_we                  out  1       1 = write
//  mem_addr                out  DATA_W  memory address
//  mem_wdata               out  DATA_W  write data
//  mem_rdata               in   DATA_W  read data; valid in the mem_ack cycle
//  mem_ack                 in   1       access complete
//  stall                   out  1       freeze upstream stages and hold the EX/MEM inputs
//  branch_taken            out  1       redirect the PC to branch_pc
//  branch_pc               out  PC_W    redirect target
//  out_wb_data             out  DATA_W  MEM/WB: write-back value
//  out_reg_write           out  REG_W   MEM/WB: destination register
//  out_WB_reg_write_signal out  1       MEM/WB: write enable (forced 0 on bubble or abort)
//  out_valid               out  1       MEM/WB: holds a retired instruction
//  mem_error               out  1       sticky flag: an access timed out
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0):
//   - FSM goes to IDLE and the timeout counter clears.
//   - All registered outputs go to 0, including mem_error.
//   - mem_req drops in the same instant it asserts reset, including mid-access.
//  Access detection: acc = in_valid & (in_MEM_mem_read_write | in_WB_mem_or_alu).
//   - The store takes priority: if both are 1, mem_we=1 and WB data is the ALU result.
//  FSM state IDLE:
//   - If acc: mem_req=1 combinationally, with addr/we/wdata taken from the inputs.
//   - acc & mem_ack in the same cycle: zero-wait completion, no stall.
//   - acc & !mem_ack: latch addr/we/wdata/reg/ctrl internally, go to WAIT, and assert stall combinationally.
//  FSM state WAIT:
//   - mem_req=1 and stall=1, with the port driven from the latched request.
//   - The counter increments each cycle.
//   - On mem_ack: complete and go to IDLE; stall drops in that cycle.
//   - If the counter reaches TIMEOUT with no ack: set mem_error and go to IDLE.
//     This retires the instruction with out_WB_reg_write_signal=0 and out_wb_data=0.
//   - A mem_ack that arrives after the abort is ignored.
//  MEM/WB register (updates on every clk edge where stall=0):
//   - out_valid <= in_valid, or the latched valid when completing from WAIT.
//   - out_wb_data <= load ? mem_rdata : alu_result.
//   - out_WB_reg_write_signal <= valid & reg_write_signal & !abort.
//   - While stall=1 the register loads a bubble: out_valid=0 and out_WB_reg_write_signal=0.
//  Branch (combinational; no memory access so it never stalls):
//   - branch_taken = in_valid & !stall & ((01&zero) | (10&!zero) | 11).
//   - branch_pc = in_new_branch_pc.
//  Latency:
//   - Non-memory ops appear on the MEM/WB outputs 1 cycle after they arrive.
//   - Loads and stores appear N+1 cycles after arrival, where N = ack wait cycles.
// STRUCTURE
//  - Shared package mips_pkg holds the widths, the PC_SRC_* encodings, and the mem_state_t enum {IDLE, WAIT}.
//  - One natural sub-module is mem_wb_reg, the MEM/WB register with a bubble-insert input.
//  - The FSM, counter and branch logic stay in mem_stage.
// TESTING
//  1. ALU op, alu=8'h3C, reg=5, we_sig=1, no acc -> next cycle out_wb_data=3C, out_reg_write=5, out_valid=1, stall=0 throughout.
//  2. Load from addr 8'h10, mem_ack after 3 cycles with rdata=8'hA5 -> stall=1 for 3 cycles, bubbles out, then out_wb_data=A5.
//  3. Store of 8'h77 to 8'h20 with zero-wait ack -> mem_we=1, mem_wdata=77, no stall, out_WB_reg_write_signal=0 if we_sig=0.
//  4. pc_src=01 with zero=1 and target 12'h0F0 -> branch_taken=1, branch_pc=0F0; repeat with zero=0 -> branch_taken=0; pc_src=10/11 likewise.
//  5. Load with no ack for TIMEOUT cycles -> mem_error=1 (sticky), retire with write-enable 0, stall drops; a late ack has no effect.
//  6. Assert rst_n=0 in WAIT cycle 2 -> mem_req=0 and stall=0 at once, all outputs 0; after release the next load completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, PC-source encodings and MEM-stage FSM state type for the MIPS pipeline.
package mips_pkg;

    localparam int unsigned MIPS_DATA_W  = 8;
    localparam int unsigned MIPS_REG_W   = 3;
    localparam int unsigned MIPS_PC_W    = 12;
    localparam int unsigned MIPS_TIMEOUT = 15;
    localparam int unsigned TMO_CNT_W    = 8;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_BEQ  = 2'b01;
    localparam logic [1:0] PC_SRC_BNE  = 2'b10;
    localparam logic [1:0] PC_SRC_JUMP = 2'b11;

    typedef enum logic [0:0] {IDLE, WAIT} mem_state_t;

    function automatic logic branch_cond(input logic [1:0] pc_src, input logic zero);
        logic taken;
        case (pc_src)
            PC_SRC_BEQ:  taken = zero;
            PC_SRC_BNE:  taken = ~zero;
            PC_SRC_JUMP: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears valid and write-enable while holding the data fields.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = MIPS_DATA_W,
    parameter int unsigned REG_W  = MIPS_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_wb_data,
    input  logic [REG_W-1:0]  in_reg_write,
    input  logic              in_reg_write_signal,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [REG_W-1:0]  out_reg_write,
    output logic              out_reg_write_signal
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid            <= 1'b0;
            out_wb_data          <= '0;
            out_reg_write        <= '0;
            out_reg_write_signal <= 1'b0;
        end else if (bubble) begin
            out_valid            <= 1'b0;
            out_reg_write_signal <= 1'b0;
        end else begin
            out_valid            <= in_valid;
            out_wb_data          <= in_wb_data;
            out_reg_write        <= in_reg_write;
            out_reg_write_signal <= in_reg_write_signal;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access with timeout abort, branch resolution,
// upstream stall generation and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = MIPS_DATA_W,
    parameter int unsigned REG_W   = MIPS_REG_W,
    parameter int unsigned PC_W    = MIPS_PC_W,
    parameter int unsigned TIMEOUT = MIPS_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [REG_W-1:0]  in_reg_write,
    input  logic              in_zero,
    input  logic [PC_W-1:0]   in_new_branch_pc,
    input  logic              in_MEM_mem_read_write,
    input  logic [1:0]        in_MEM_pc_src,
    input  logic              in_WB_mem_or_alu,
    input  logic              in_WB_reg_write_signal,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              branch_taken,
    output logic [PC_W-1:0]   branch_pc,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [REG_W-1:0]  out_reg_write,
    output logic              out_WB_reg_write_signal,
    output logic              out_valid,
    output logic              mem_error
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT);

    mem_state_t           state_q;
    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_nxt;
    logic [DATA_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 we_q;
    logic                 load_q;
    logic [REG_W-1:0]     reg_q;
    logic                 wsig_q;
    logic                 mem_error_q;

    logic                 acc;
    logic                 in_load;
    logic                 abort;
    logic                 wb_valid;
    logic [DATA_W-1:0]    wb_data;
    logic [REG_W-1:0]     wb_reg;
    logic                 wb_wsig;

    // A store wins over a load, so a load is only a load when no store is requested.
    assign acc     = in_valid & (in_MEM_mem_read_write | in_WB_mem_or_alu);
    assign in_load = in_WB_mem_or_alu & ~in_MEM_mem_read_write;
    assign cnt_nxt = cnt_q + 1'b1;
    assign abort   = (state_q == WAIT) & ~mem_ack & (cnt_nxt == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            load_q      <= 1'b0;
            reg_q       <= '0;
            wsig_q      <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc && !mem_ack) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                        addr_q  <= in_alu_result;
                        wdata_q <= in_data_2;
                        we_q    <= in_MEM_mem_read_write;
                        load_q  <= in_load;
                        reg_q   <= in_reg_write;
                        wsig_q  <= in_WB_reg_write_signal;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_nxt;
                    if (mem_ack || abort) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (abort) begin
                mem_error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = in_alu_result;
        mem_wdata = in_data_2;
        stall     = 1'b0;
        wb_valid  = in_valid;
        wb_data   = (acc & in_load) ? mem_rdata : in_alu_result;
        wb_reg    = in_reg_write;
        wb_wsig   = in_valid & in_WB_reg_write_signal;
        case (state_q)
            IDLE: begin
                mem_req = acc;
                mem_we  = acc & in_MEM_mem_read_write;
                stall   = acc & ~mem_ack;
            end
            WAIT: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                stall     = ~mem_ack & ~abort;
                wb_valid  = 1'b1;
                wb_data   = abort ? '0 : (load_q ? mem_rdata : addr_q);
                wb_reg    = reg_q;
                wb_wsig   = wsig_q & ~abort;
            end
            default: ;
        endcase
        // Request and stall must fall the moment reset asserts, even with a live request upstream.
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            stall   = 1'b0;
        end
    end

    assign branch_taken = in_valid & ~stall & branch_cond(in_MEM_pc_src, in_zero);
    assign branch_pc    = in_new_branch_pc;
    assign mem_error    = mem_error_q;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bubble               (stall),
        .in_valid             (wb_valid),
        .in_wb_data           (wb_data),
        .in_reg_write         (wb_reg),
        .in_reg_write_signal  (wb_wsig),
        .out_valid            (out_valid),
        .out_wb_data          (out_wb_data),
        .out_reg_write        (out_reg_write),
        .out_reg_write_signal (out_WB_reg_write_signal)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a behavioural memory and pipeline model.
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_alu_result;
    logic [7:0]  in_data_2;
    logic [2:0]  in_reg_write;
    logic        in_zero;
    logic [11:0] in_new_branch_pc;
    logic        in_MEM_mem_read_write;
    logic [1:0]  in_MEM_pc_src;
    logic        in_WB_mem_or_alu;
    logic        in_WB_reg_write_signal;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_pc;
    logic [7:0]  out_wb_data;
    logic [2:0]  out_reg_write;
    logic        out_WB_reg_write_signal;
    logic        out_valid;
    logic        mem_error;

    mem_stage #(
        .DATA_W  (8),
        .REG_W   (3),
        .PC_W    (12),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_valid                (in_valid),
        .in_alu_result           (in_alu_result),
        .in_data_2               (in_data_2),
        .in_reg_write            (in_reg_write),
        .in_zero                 (in_zero),
        .in_new_branch_pc        (in_new_branch_pc),
        .in_MEM_mem_read_write   (in_MEM_mem_read_write),
        .in_MEM_pc_src           (in_MEM_pc_src),
        .in_WB_mem_or_alu        (in_WB_mem_or_alu),
        .in_WB_reg_write_signal  (in_WB_reg_write_signal),
        .mem_req                 (mem_req),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .mem_ack                 (mem_ack),
        .stall                   (stall),
        .branch_taken            (branch_taken),
        .branch_pc               (branch_pc),
        .out_wb_data             (out_wb_data),
        .out_reg_write           (out_reg_write),
        .out_WB_reg_write_signal (out_WB_reg_write_signal),
        .out_valid               (out_valid),
        .mem_error               (mem_error)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] rd;
        logic       we;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [256];
    int         checks   = 0;
    int         failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit br_expect(input logic [1:0] ps, input logic z);
        case (ps)
            2'd1:    return z;
            2'd2:    return !z;
            2'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: every retirement on the MEM/WB outputs must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_retire: out_valid=1 with wb_data=%0h, required no retirement",
                         out_wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_data", out_wb_data, e.data);
                check("wb_reg", out_reg_write, e.rd);
                check("wb_we", out_WB_reg_write_signal, e.we);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the instruction leaves the stage.
    task automatic issue(input logic v, input logic [7:0] alu, input logic [7:0] d2,
                         input logic [2:0] rd, input logic z, input logic [11:0] tgt,
                         input logic st, input logic [1:0] ps, input logic ld, input logic ws,
                         input int unsigned nwait);
        bit   acc_e;
        exp_t e;
        acc_e                  = v && (st || ld);
        in_valid               = v;
        in_alu_result          = alu;
        in_data_2              = d2;
        in_reg_write           = rd;
        in_zero                = z;
        in_new_branch_pc       = tgt;
        in_MEM_mem_read_write  = st;
        in_MEM_pc_src          = ps;
        in_WB_mem_or_alu       = ld;
        in_WB_reg_write_signal = ws;
        if (acc_e) begin
            for (int k = 0; k <= int'(nwait); k++) begin
                mem_ack   = (k == int'(nwait));
                mem_rdata = (k == int'(nwait)) ? mem[alu] : 8'($urandom);
                @(negedge clk);
                check("mem_req", mem_req, 1);
                check("mem_addr", mem_addr, alu);
                check("mem_we", mem_we, st);
                if (st) check("mem_wdata", mem_wdata, d2);
                check("stall_mem", stall, (k != int'(nwait)));
                check("branch_mem", branch_taken, (k == int'(nwait)) && br_expect(ps, z));
                check("branch_pc", branch_pc, tgt);
                if (k == int'(nwait)) begin
                    e.data = st ? alu : mem[alu];
                    e.rd   = rd;
                    e.we   = ws;
                    exp_q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
            mem_ack = 1'b0;
            if (st) mem[alu] = d2;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            @(negedge clk);
            check("stall_alu", stall, 0);
            check("mem_req_idle", mem_req, 0);
            check("branch_alu", branch_taken, v && br_expect(ps, z));
            check("branch_pc", branch_pc, tgt);
            if (v) begin
                e.data = alu;
                e.rd   = rd;
                e.we   = ws;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bubble();
        in_valid              = 1'b0;
        in_MEM_mem_read_write = 1'b0;
        in_WB_mem_or_alu      = 1'b0;
        in_MEM_pc_src         = 2'b00;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned stall_cnt;
        bit          done;
        exp_t        e;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        drive_bubble();
        in_alu_result          = '0;
        in_data_2              = '0;
        in_reg_write           = '0;
        in_zero                = 1'b0;
        in_new_branch_pc       = '0;
        in_WB_reg_write_signal = 1'b0;
        mem_ack                = 1'b0;
        mem_rdata              = '0;
        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_wb_data", out_wb_data, 0);
        check("rst_wb_reg", out_reg_write, 0);
        check("rst_wb_we", out_WB_reg_write_signal, 0);
        check("rst_mem_error", mem_error, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: ALU op, multi-cycle load, zero-wait store, branch decisions.
        issue(1, 8'h3C, 8'h00, 3'd5, 0, 12'h000, 0, 2'b00, 0, 1, 0);
        mem[8'h10] = 8'hA5;
        issue(1, 8'h10, 8'h00, 3'd2, 0, 12'h000, 0, 2'b00, 1, 1, 3);
        issue(1, 8'h20, 8'h77, 3'd1, 0, 12'h000, 1, 2'b00, 0, 0, 0);
        issue(1, 8'h00, 8'h00, 3'd0, 1, 12'h0F0, 0, 2'b01, 0, 0, 0);
        issue(1, 8'h00, 8'h00, 3'd0, 0, 12'h0F0, 0, 2'b01, 0, 0, 0);
        issue(1, 8'h00, 8'h00, 3'd0, 0, 12'h0F1, 0, 2'b10, 0, 0, 0);
        issue(1, 8'h00, 8'h00, 3'd0, 1, 12'h0F2, 0, 2'b10, 0, 0, 0);
        issue(1, 8'h00, 8'h00, 3'd0, 1, 12'h0F3, 0, 2'b11, 0, 0, 0);
        issue(0, 8'h00, 8'h00, 3'd0, 1, 12'h0F4, 0, 2'b11, 0, 0, 0);
        // Store and load together: the store wins and the ALU result is written back.
        issue(1, 8'h44, 8'h99, 3'd3, 0, 12'h000, 1, 2'b00, 1, 1, 2);
        issue(1, 8'h44, 8'h00, 3'd4, 0, 12'h000, 0, 2'b00, 1, 1, 0);

        for (int n = 0; n < 200; n++) begin
            int unsigned kind;
            int unsigned w;
            kind = $urandom_range(3);
            w    = ($urandom_range(2) == 0) ? $urandom_range(6) : 0;
            issue(($urandom_range(9) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom), 12'($urandom), (kind >= 2), 2'($urandom),
                  (kind == 1 || kind == 3), 1'($urandom), w);
        end
        check("no_error_yet", mem_error, 0);

        // Timeout: load never acknowledged.
        in_valid               = 1'b1;
        in_alu_result          = 8'h55;
        in_reg_write           = 3'd6;
        in_MEM_mem_read_write  = 1'b0;
        in_WB_mem_or_alu       = 1'b1;
        in_WB_reg_write_signal = 1'b1;
        in_MEM_pc_src          = 2'b00;
        mem_ack                = 1'b0;
        stall_cnt              = 0;
        done                   = 0;
        for (int k = 0; k < int'(TIMEOUT) + 5 && !done; k++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            else done = 1;
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        check("timeout_stall_cycles", stall_cnt, TIMEOUT);
        e.data = 8'h00;
        e.rd   = 3'd6;
        e.we   = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        drive_bubble();
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        @(negedge clk);
        check("timeout_error_set", mem_error, 1);
        check("late_ack_no_req", mem_req, 0);
        check("late_ack_no_stall", stall, 0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("error_sticky", mem_error, 1);
        check("late_ack_no_retire", out_valid, 0);
        @(posedge clk);
        #1;

        // Reset asserted in the second WAIT cycle of a load.
        in_valid               = 1'b1;
        in_alu_result          = 8'h33;
        in_reg_write           = 3'd2;
        in_MEM_mem_read_write  = 1'b0;
        in_WB_mem_or_alu       = 1'b1;
        in_WB_reg_write_signal = 1'b1;
        @(negedge clk);
        check("pre_reset_stall", stall, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mem_req", mem_req, 0);
        check("reset_stall", stall, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_wb_data", out_wb_data, 0);
        check("reset_wb_we", out_WB_reg_write_signal, 0);
        check("reset_error_clear", mem_error, 0);
        drive_bubble();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 8'h33, 8'h00, 3'd2, 0, 12'h000, 0, 2'b00, 1, 1, 2);

        drive_bubble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_error_clear", mem_error, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
